// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Parity support in the transmitter is enabled with FIFO_UART_TX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // PARITY stays in the enum even when the parity build option is off
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each serial bit.
module uart_baud_cnt #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_count;

  // clear realigns the bit period to the first cycle of a newly entered state
  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bit_end = (r_count == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter draining the read side of a FIFO, one byte per frame.
// Defining FIFO_UART_TX_PARITY_EN adds an even parity bit between the data bits and the stop bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_nextState;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_W-1:0]      r_bitIdx;
  logic [IDX_W-1:0]      w_bitIdxNext;
  logic                  r_tx;
  logic                  w_txNext;
  logic                  w_bitEnd;
  logic                  w_stateChange;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  assign w_stateChange = (w_nextState != r_state);

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baudCnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_stateChange),
    .bit_end(w_bitEnd)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (!empty) w_nextState = FETCH;
      FETCH: w_nextState = LOAD;
      LOAD:  w_nextState = START;
      START: if (w_bitEnd) w_nextState = DATA;
      DATA: begin
        if (w_bitEnd && (r_bitIdx == LAST_IDX)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          w_nextState = PARITY;
`else
          w_nextState = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (w_bitEnd) w_nextState = STOP;
`endif
      STOP:  if (w_bitEnd) w_nextState = empty ? IDLE : FETCH;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_bitIdxNext = r_bitIdx;
    if (r_state == LOAD) begin
      w_bitIdxNext = '0;
    end else if ((r_state == DATA) && w_bitEnd) begin
      w_bitIdxNext = r_bitIdx + IDX_W'(1);
    end
  end

  // line level is chosen one cycle ahead from the next state so tx can come straight from a flop
  always_comb begin
    w_txNext = UART_IDLE_LEVEL;
    case (w_nextState)
      START:  w_txNext = 1'b0;
      DATA:   w_txNext = r_data[w_bitIdxNext[IDX_W-2:0]];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: w_txNext = r_parity;
`endif
      default: w_txNext = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tx     <= UART_IDLE_LEVEL;
      r_bitIdx <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_nextState;
      r_tx     <= w_txNext;
      r_bitIdx <= w_bitIdxNext;
      if (r_state == LOAD) begin
        r_data <= rd_data;
      end
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // parity is taken from the FIFO word while it is being loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (r_state == LOAD) begin
      r_parity <= even_parity(rd_data);
    end
  end
`endif

  assign rd_en   = (r_state == FETCH);
  assign busy    = (r_state != IDLE);
  assign tx_done = (r_state == STOP) && w_bitEnd;
  assign tx      = r_tx;

endmodule
